// File: rtl/loop_checker.sv
// Rotating-pattern loop checker: infers rotation direction, locks after LOCK_CNT steps, flags breaks.
// Optional macro LOOP_CHECKER_STICKY_EN: first break latches a FAULT state (fault port) until reset.
module loop_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         pat_in,
    output logic                     locked,
    output logic                     dir,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     err,
    output logic [ERR_W-1:0]         err_cnt
`ifdef LOOP_CHECKER_STICKY_EN
    ,
    output logic                     fault
`endif
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
`ifdef LOOP_CHECKER_STICKY_EN
        ,
        FAULT
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [CW-1:0]    match_cnt, match_cnt_nxt;
    logic             cand_dir, cand_dir_nxt;
    logic             locked_nxt, dir_nxt, err_nxt;
    logic [PW-1:0]    pos_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;

    logic [WIDTH-1:0] rot_l, rot_r, exp_pat;
    logic             hit_l, hit_r, step_dir;
    logic [CW-1:0]    new_cnt;
    logic [PW-1:0]    pos_inc, pos_dec;
    logic [ERR_W-1:0] err_cnt_sat;

    assign rot_l       = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign rot_r       = {prev[0], prev[WIDTH-1:1]};
    assign hit_l       = (pat_in == rot_l);
    assign hit_r       = (pat_in == rot_r);
    assign exp_pat     = dir ? rot_r : rot_l;
    assign pos_inc     = (pos == PW'(WIDTH - 1)) ? '0 : pos + PW'(1);
    assign pos_dec     = (pos == '0) ? PW'(WIDTH - 1) : pos - PW'(1);
    assign err_cnt_sat = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);

    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        match_cnt_nxt = match_cnt;
        cand_dir_nxt  = cand_dir;
        locked_nxt    = locked;
        dir_nxt       = dir;
        pos_nxt       = pos;
        err_nxt       = 1'b0;
        err_cnt_nxt   = err_cnt;
        step_dir      = hit_r;
        new_cnt       = '0;

        if (en) begin
            case (state)
                IDLE: begin
                    prev_nxt      = pat_in;
                    state_nxt     = SEARCH;
                    match_cnt_nxt = '0;
                end
                SEARCH: begin
                    prev_nxt = pat_in;
                    // Ambiguous samples (symmetric patterns) neither help nor hurt the candidate.
                    if (hit_l && hit_r) begin
                        match_cnt_nxt = match_cnt;
                    end else if (hit_l || hit_r) begin
                        new_cnt       = (match_cnt == '0 || step_dir == cand_dir) ?
                                        match_cnt + CW'(1) : CW'(1);
                        cand_dir_nxt  = step_dir;
                        match_cnt_nxt = new_cnt;
                        if (new_cnt == CW'(LOCK_CNT)) begin
                            state_nxt     = LOCKED;
                            dir_nxt       = step_dir;
                            pos_nxt       = '0;
                            locked_nxt    = 1'b1;
                            match_cnt_nxt = '0;
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    prev_nxt = pat_in;
                    if (pat_in == exp_pat) begin
                        pos_nxt = dir ? pos_dec : pos_inc;
                    end else begin
                        err_nxt       = 1'b1;
                        err_cnt_nxt   = err_cnt_sat;
                        locked_nxt    = 1'b0;
                        match_cnt_nxt = '0;
`ifdef LOOP_CHECKER_STICKY_EN
                        state_nxt     = FAULT;
`else
                        state_nxt     = SEARCH;
`endif
                    end
                end
                default: begin
                    // FAULT (sticky build) ignores strobes until reset.
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            prev      <= '0;
            match_cnt <= '0;
            cand_dir  <= 1'b0;
            locked    <= 1'b0;
            dir       <= 1'b0;
            pos       <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            match_cnt <= match_cnt_nxt;
            cand_dir  <= cand_dir_nxt;
            locked    <= locked_nxt;
            dir       <= dir_nxt;
            pos       <= pos_nxt;
            err       <= err_nxt;
            err_cnt   <= err_cnt_nxt;
        end
    end

`ifdef LOOP_CHECKER_STICKY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault <= 1'b0;
        end else begin
            fault <= (state_nxt == FAULT);
        end
    end
`endif

endmodule

// File: tb/tb_loop_checker.sv
// Directed bench for loop_checker: scoreboard queue of expected outputs, checked one cycle after each sample.
module tb_loop_checker;

`ifdef LOOP_CHECKER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] pat_in = 8'h00;

    logic       locked, dir, err;
    logic [2:0] pos;
    logic [7:0] err_cnt;
    logic       locked_s, dir_s, err_s;
    logic [2:0] pos_s;
    logic [1:0] err_cnt_s;
`ifdef LOOP_CHECKER_STICKY_EN
    logic       fault, fault_s;
`endif

    typedef struct packed {
        logic       locked;
        logic       dir;
        logic [2:0] pos;
        logic       err;
        logic [7:0] err_cnt;
        logic       fault;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    loop_checker #(.WIDTH(8), .LOCK_CNT(3), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .en(en), .pat_in(pat_in),
        .locked(locked), .dir(dir), .pos(pos), .err(err), .err_cnt(err_cnt)
`ifdef LOOP_CHECKER_STICKY_EN
        , .fault(fault)
`endif
    );

    loop_checker #(.WIDTH(8), .LOCK_CNT(3), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .pat_in(pat_in),
        .locked(locked_s), .dir(dir_s), .pos(pos_s), .err(err_s), .err_cnt(err_cnt_s)
`ifdef LOOP_CHECKER_STICKY_EN
        , .fault(fault_s)
`endif
    );

    function automatic exp_t mk(logic l, logic d, logic [2:0] p, logic e, int c, logic f);
        exp_t x;
        x.locked  = l;
        x.dir     = d;
        x.pos     = p;
        x.err     = e;
        x.err_cnt = 8'(c);
        x.fault   = f;
        return x;
    endfunction

    task automatic check1(string tag, logic [7:0] obs, logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t x;
        logic [7:0] sat_exp;
        n_chk++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            sat_exp = (x.err_cnt > 8'd3) ? 8'd3 : x.err_cnt;
            check1("locked",    {7'd0, locked},    {7'd0, x.locked});
            check1("dir",       {7'd0, dir},       {7'd0, x.dir});
            check1("pos",       {5'd0, pos},       {5'd0, x.pos});
            check1("err",       {7'd0, err},       {7'd0, x.err});
            check1("err_cnt",   err_cnt,           x.err_cnt);
            check1("sat_locked",{7'd0, locked_s},  {7'd0, x.locked});
            check1("sat_err",   {7'd0, err_s},     {7'd0, x.err});
            check1("sat_cnt",   {6'd0, err_cnt_s}, sat_exp);
`ifdef LOOP_CHECKER_STICKY_EN
            check1("fault",     {7'd0, fault},     {7'd0, x.fault});
            check1("sat_fault", {7'd0, fault_s},   {7'd0, x.fault});
`endif
        end
    endtask

    task automatic step(logic e, logic [7:0] p, exp_t x);
        @(negedge clk);
        en     = e;
        pat_in = p;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        en     = 1'b1;
        pat_in = 8'h38;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        compare_out();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
    endtask

    initial begin
        int cnt;

        // Left lock
        do_reset();
        step(1, 8'h07, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h0E, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h1C, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h38, mk(1, 0, 0, 0, 0, 0));
        step(1, 8'h70, mk(1, 0, 1, 0, 0, 0));

        // Strobe gaps: pat_in toggles but nothing may move
        for (int i = 0; i < 5; i++)
            step(0, 8'($urandom), mk(1, 0, 1, 0, 0, 0));
        step(1, 8'hE0, mk(1, 0, 2, 0, 0, 0));

        // Break and relock (sticky build parks in FAULT)
        step(1, 8'h13, mk(0, 0, 2, 1, 1, STICKY));
        step(1, 8'h26, mk(0, 0, 2, 0, 1, STICKY));
        step(1, 8'h4C, mk(0, 0, 2, 0, 1, STICKY));
        step(1, 8'h98, STICKY ? mk(0, 0, 2, 0, 1, 1) : mk(1, 0, 0, 0, 1, 0));

        // Reset mid-lock with en high
        do_reset();

        // Right lock with wrap-around
        step(1, 8'h07, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h83, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'hC1, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'hE0, mk(1, 1, 0, 0, 0, 0));
        step(1, 8'h70, mk(1, 1, 7, 0, 0, 0));

        // Ambiguous samples never lock
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1, 8'hFF, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h01, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h02, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h04, mk(0, 0, 0, 0, 0, 0));
        step(1, 8'h08, mk(1, 0, 0, 0, 0, 0));

        // Five breaks: 8-bit counter reaches 5, 2-bit counter sticks at 3
        for (int i = 1; i <= 5; i++) begin
            cnt = STICKY ? 1 : i;
            step(1, 8'h81, mk(0, 0, 0, (!STICKY || i == 1), cnt, STICKY));
            step(1, 8'h03, mk(0, 0, 0, 0, cnt, STICKY));
            step(1, 8'h06, mk(0, 0, 0, 0, cnt, STICKY));
            step(1, 8'h0C, mk(!STICKY, 0, 0, 0, cnt, STICKY));
        end

        // Reset clears the counters and any fault
        do_reset();

        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
